// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic MIPS instructions into 32-bit words and streams them into IM through a FIFO.
// Define INSTR_ENCODER_CHKSUM_EN to keep a running XOR checksum of every completed write on chksum.
module instr_encoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_sel,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [25:0]       in_imm,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic              im_we,
    input  logic              im_ready,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   wcount,
    output logic              busy,
    output logic              err,
    output logic              wrap,
    output logic [31:0]       chksum
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [5:0]  op, funct;
    logic        is_r, is_i, legal, shift;
    logic [4:0]  rs_f, rt_f, rd_f, sh_f;
    logic [31:0] word;

    always_comb begin
        op    = 6'b000000;
        funct = 6'b000000;
        case (in_sel)
            5'd0:    funct = 6'b100000;
            5'd1:    funct = 6'b100010;
            5'd2:    funct = 6'b100100;
            5'd3:    funct = 6'b100101;
            5'd4:    funct = 6'b100110;
            5'd5:    funct = 6'b100111;
            5'd6:    funct = 6'b101010;
            5'd7:    funct = 6'b000000;
            5'd8:    funct = 6'b000010;
            5'd9:    funct = 6'b001000;
            5'd10:   funct = 6'b001001;
            5'd11:   op    = 6'b100011;
            5'd12:   op    = 6'b101011;
            5'd13:   op    = 6'b000100;
            5'd14:   op    = 6'b000101;
            5'd15:   op    = 6'b001000;
            5'd16:   op    = 6'b001100;
            5'd17:   op    = 6'b001010;
            5'd18:   op    = 6'b100001;
            5'd19:   op    = 6'b101001;
            5'd20:   op    = 6'b000010;
            5'd21:   op    = 6'b000011;
            default: op    = 6'b000000;
        endcase
    end

    // Shifts take their operand from rt, so rs is dropped; every other R-type drops shamt.
    always_comb begin
        is_r  = in_sel <= 5'd10;
        is_i  = in_sel >= 5'd11 && in_sel <= 5'd19;
        legal = in_sel <= 5'd21;
        shift = in_sel == 5'd7 || in_sel == 5'd8;
        rs_f  = shift ? 5'd0 : in_rs;
        sh_f  = shift ? in_shamt : 5'd0;
        rt_f  = (in_sel == 5'd9 || in_sel == 5'd10) ? 5'd0 : in_rt;
        rd_f  = in_sel == 5'd9 ? 5'd0 : in_rd;
        word  = is_r ? {6'b000000, rs_f, rt_f, rd_f, sh_f, funct}
              : is_i ? {op, in_rs, in_rt, in_imm[15:0]}
              : {op, in_imm};
    end

    logic [0:0]        state_q, state_d;
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    fill_q, fill_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_inc, out_addr_q, out_addr_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [ADDR_W:0]   wcount_q, wcount_d;
    logic              err_q, err_d, wrap_q, wrap_d;
    logic              full, empty, accept, push, pop, done, start_ok;

    always_comb begin
        full     = fill_q == (PTR_W+1)'(DEPTH);
        empty    = fill_q == '0;
        accept   = in_valid && !full;
        push     = accept && legal;
        done     = state_q == WRITE && im_ready;
        pop      = !empty && (state_q == IDLE || done);
        start_ok = start && empty && state_q == IDLE && !accept;
    end

    // A back-to-back pop lands on the address after the word completing this edge.
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = word;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        fill_d     = fill_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        addr_inc   = addr_q + 1'b1;
        addr_d     = start_ok ? start_addr : done ? addr_inc : addr_q;
        state_d    = pop ? WRITE : done ? IDLE : state_q;
        out_data_d = pop ? mem_q[rd_ptr_q] : out_data_q;
        out_addr_d = pop ? (done ? addr_inc : addr_q) : out_addr_q;
        wcount_d   = start_ok ? '0 : (done && wcount_q != '1) ? wcount_q + 1'b1 : wcount_q;
        wrap_d     = start_ok ? 1'b0 : (done && addr_q == '1) ? 1'b1 : wrap_q;
        err_d      = accept && !legal;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            addr_q     <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
            wcount_q   <= '0;
            err_q      <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            addr_q     <= addr_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
            wcount_q   <= wcount_d;
            err_q      <= err_d;
            wrap_q     <= wrap_d;
        end
    end

`ifdef INSTR_ENCODER_CHKSUM_EN
    logic [31:0] chk_q, chk_d;

    always_comb chk_d = start_ok ? '0 : done ? chk_q ^ out_data_q : chk_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) chk_q <= '0;
        else      chk_q <= chk_d;
    end

    assign chksum = chk_q;
`else
    assign chksum = '0;
`endif

    assign in_ready = !full;
    assign im_we    = state_q == WRITE;
    assign im_addr  = out_addr_q;
    assign im_wdata = out_data_q;
    assign wcount   = wcount_q;
    assign busy     = !empty || state_q == WRITE;
    assign err      = err_q;
    assign wrap     = wrap_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed beats with hand-computed words; a negedge monitor checks every IM write against a queue.
module tb_instr_encoder;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0, rst = 1'b0;
    logic              in_valid = 1'b0, in_ready;
    logic [4:0]        in_sel = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [25:0]       in_imm = '0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic              im_we, im_ready = 1'b1;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic [ADDR_W:0]   wcount;
    logic              busy, err, wrap;
    logic [31:0]       chksum;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_imm(in_imm), .start(start), .start_addr(start_addr),
        .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
        .wcount(wcount), .busy(busy), .err(err), .wrap(wrap), .chksum(chksum)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t               exp_q[$];
    wr_t               e;
    int                checks = 0, errors = 0;
    int                cyc = 0, last_wcyc = 0, prev_wcyc = 0;
    logic [31:0]       m_chk = '0;
    logic [ADDR_W:0]   m_wcount = '0;
    logic [ADDR_W-1:0] m_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst && im_we && im_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", im_addr, im_wdata);
            end else begin
                e = exp_q.pop_front();
                check("im_addr", 32'(im_addr), 32'(e.a));
                check("im_wdata", im_wdata, e.d);
                m_chk = m_chk ^ e.d;
                m_wcount = m_wcount + 1'b1;
            end
            prev_wcyc = last_wcyc;
            last_wcyc = cyc;
        end
    end

    task automatic send(input logic [4:0] sel, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [25:0] imm,
                        input logic [31:0] w);
        bit ok = 0;
        in_sel = sel; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                ok = 1;
            end
        end
        #1 in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: sel %0d got no accept expected accept", sel);
        end else if (sel <= 5'd21) begin
            exp_q.push_back('{m_addr, w});
            m_addr = m_addr + 1'b1;
        end
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a);
        start_addr = a;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        m_addr = a;
        m_wcount = '0;
        m_chk = '0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = !busy && exp_q.size() == 0;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got busy %0b pending %0d expected idle", busy, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_wcount"}, 32'(wcount), 32'(m_wcount));
`ifdef INSTR_ENCODER_CHKSUM_EN
        check({tag, "_chksum"}, chksum, m_chk);
`else
        check({tag, "_chksum"}, chksum, 32'h0);
`endif
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_im_we", 32'(im_we), 32'h0);
        check("rst_im_addr", 32'(im_addr), 32'h0);
        check("rst_im_wdata", im_wdata, 32'h0);
        check("rst_wcount", 32'(wcount), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_chksum", chksum, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        do_start(8'h10);
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0, 32'h00221820);
        @(negedge clk);
        check("latency_we_k", 32'(im_we), 32'h0);
        @(negedge clk);
        check("latency_we_k1", 32'(im_we), 32'h1);
        drain();
        check("add_wcount", 32'(wcount), 32'h1);

        send(5'd11, 5'd29, 5'd8, 5'd0, 5'd0, 26'h4, 32'h8FA80004);
        send(5'd20, 5'd0, 5'd0, 5'd0, 5'd0, 26'h10, 32'h08000010);
        drain();
        check("b2b_gap", 32'(last_wcyc - prev_wcyc), 32'h1);
        check_stats("b2b");

        send(5'd7, 5'd7, 5'd1, 5'd2, 5'd4, 26'h0, 32'h00011100);
        drain();

        im_ready = 1'b0;
        send(5'd1, 5'd3, 5'd4, 5'd5, 5'd0, 26'h0, 32'h00642822);
        send(5'd2, 5'd1, 5'd1, 5'd1, 5'd7, 26'h0, 32'h00210824);
        send(5'd8, 5'd9, 5'd3, 5'd4, 5'd31, 26'h0, 32'h000327C2);
        send(5'd9, 5'd31, 5'd5, 5'd6, 5'd3, 26'h0, 32'h03E00008);
        send(5'd10, 5'd4, 5'd7, 5'd31, 5'd1, 26'h0, 32'h0080F809);
        repeat (3) @(negedge clk);
        check("full_in_ready", 32'(in_ready), 32'h0);
        check("stall_im_we", 32'(im_we), 32'h1);
        check("stall_wdata_a", im_wdata, 32'h00642822);
        check("stall_addr", 32'(im_addr), 32'h14);
        repeat (2) @(negedge clk);
        check("stall_wdata_b", im_wdata, 32'h00642822);
        @(posedge clk);
        #1 im_ready = 1'b1;
        send(5'd15, 5'd2, 5'd3, 5'd0, 5'd0, 26'h3FFFF, 32'h2043FFFF);
        drain();
        check_stats("bp");

        send(5'd25, 5'd1, 5'd2, 5'd3, 5'd4, 26'h5, 32'h0);
        @(negedge clk);
        check("illegal_err", 32'(err), 32'h1);
        check("illegal_we", 32'(im_we), 32'h0);
        @(negedge clk);
        check("illegal_err_pulse", 32'(err), 32'h0);
        check("illegal_busy", 32'(busy), 32'h0);
        check_stats("illegal");

        do_start(8'hFF);
        check("start_wcount", 32'(wcount), 32'h0);
        send(5'd21, 5'd0, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 32'h0FFFFFFF);
        send(5'd12, 5'd5, 5'd6, 5'd0, 5'd0, 26'h2FFFC, 32'hACA6FFFC);
        drain();
        check("wrap_set", 32'(wrap), 32'h1);
        check_stats("wrap");
        do_start(8'h00);
        check("wrap_clear", 32'(wrap), 32'h0);

        im_ready = 1'b0;
        send(5'd13, 5'd1, 5'd2, 5'd0, 5'd0, 26'h8000, 32'h10228000);
        send(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0, 32'h00221820);
        send(5'd11, 5'd29, 5'd8, 5'd0, 5'd0, 26'h4, 32'h8FA80004);
        @(negedge clk);
        check("pre_rst_we", 32'(im_we), 32'h1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async_rst_we", 32'(im_we), 32'h0);
        exp_q.delete();
        m_wcount = '0;
        m_chk = '0;
        m_addr = '0;
        @(posedge clk);
        #1 rst = 1'b1;
        im_ready = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'h0);
        check("post_rst_wcount", 32'(wcount), 32'h0);
        check("post_rst_in_ready", 32'(in_ready), 32'h1);
        check("post_rst_wrap", 32'(wrap), 32'h0);
        repeat (3) @(negedge clk);
        check("post_rst_no_we", 32'(im_we), 32'h0);
        @(posedge clk);
        #1;
        send(5'd3, 5'd4, 5'd5, 5'd6, 5'd0, 26'h0, 32'h00853025);
        drain();
        check_stats("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the single-cycle datapath's opcode/funct decoder: packs a symbolic instruction (select code plus register, shamt and immediate fields) into a 32-bit MIPS word.
- Buffers encoded words in a small FIFO and streams them sequentially into instruction memory through a write port with backpressure.
- Used as the program loader that fills IM before the core runs, and by benches to build test programs.

Parameters:
- DEPTH, 4, FIFO entries; power of 2, at least 2.
- ADDR_W, 8, IM word-address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction beat valid.
- in_ready  out  1  beat accepted on an edge where in_valid && in_ready.
- in_sel  in  5  instruction select (encoding table below).
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shamt fields.
- in_imm  in  26  immediate; I-type uses bits [15:0], J-type uses all 26.
- start  in  1  load start_addr into the address counter and clear wcount.
- start_addr  in  ADDR_W  first IM word address.
- im_we  out  1  IM write request.
- im_ready  in  1  IM accepts; a write completes on an edge where im_we && im_ready.
- im_addr  out  ADDR_W  word address.
- im_wdata  out  32  encoded word.
- wcount  out  ADDR_W+1  completed writes since reset or start; saturates at all-ones.
- busy  out  1  FIFO non-empty or im_we high.
- err  out  1  one-cycle pulse on acceptance of an illegal in_sel.
- wrap  out  1  sticky; set when im_addr wraps from max to 0; cleared by start.
- chksum  out  32  see Optional Feature.

Behaviour:
- Encoding table, sel: mnemonic, opcode/funct.
  - R-type, opcode 000000: 0 add 100000, 1 sub 100010, 2 and 100100, 3 or 100101, 4 xor 100110, 5 nor 100111, 6 slt 101010, 7 sll 000000, 8 srl 000010, 9 jr 001000, 10 jalr 001001.
  - I-type: 11 lw 100011, 12 sw 101011, 13 beq 000100, 14 bne 000101, 15 addi 001000, 16 andi 001100, 17 slti 001010, 18 lh 100001, 19 sh 101001.
  - J-type: 20 j 000010, 21 jal 000011.
  - sel 22..31 are illegal.
- Word layout:
  - R: {000000, rs, rt, rd, shamt, funct}.
  - I: {op, rs, rt, imm[15:0]}.
  - J: {op, imm[25:0]}.
- Field forcing:
  - sll/srl: rs = 0.
  - All other R-type: shamt = 0.
  - jr: rt = rd = 0.
  - jalr: rt = 0.
  - Unused input bits are ignored.
- Encoding is combinational. The encoded word is pushed into the FIFO on the accept edge.
- in_ready = !fifo_full, independent of in_valid.
- Illegal sel:
  - Still handshaken (in_ready is honoured).
  - Nothing is pushed.
  - err is high in the cycle after the accept edge.
- Writer FSM:
  - IDLE: im_we = 0. On an edge with FIFO non-empty, pop the head into the output register (im_wdata, im_addr = counter) and go to WRITE.
  - WRITE: im_we = 1; outputs held stable while !im_ready.
  - On an edge with im_ready in WRITE:
    - Increment the counter modulo 2^ADDR_W; set wrap if the counter was 2^ADDR_W-1.
    - Increment wcount.
    - If the FIFO is non-empty, pop the next word in the same edge and stay in WRITE (back-to-back, one word per cycle); else go to IDLE.
- Latency: a beat accepted at edge k with the FIFO empty and the FSM in IDLE gives im_we = 1 after edge k+1.
- Capacity: DEPTH + 1 words (FIFO plus output register).
- Simultaneous push and pop on a full FIFO: the push is blocked by in_ready = 0. The freed slot raises in_ready in the next cycle.
- start:
  - Honoured only when busy = 0 and no beat is accepted in the same cycle; otherwise ignored.
  - Loads the counter, clears wcount and wrap.
- Reset values (rst = 0, asynchronous):
  - FSM in IDLE, FIFO empty, counter 0.
  - im_we = 0, im_addr = 0, im_wdata = 0, wcount = 0, err = 0, wrap = 0, chksum = 0, busy = 0, in_ready = 1.
- Reset mid-write discards all buffered words; no partial-write recovery.

Optional Feature:
- Macro: INSTR_ENCODER_CHKSUM_EN.
- Defined: chksum is a running XOR of every completed im_wdata, updated on the write-complete edge and cleared by reset or an honoured start.
- Not defined: chksum is tied to 0 and no register is inferred.
- The port exists in both builds.

Test Plan:
- start, start_addr = 0x10; beat sel=0, rs=1, rt=2, rd=3 -> one write: im_addr = 0x10, im_wdata = 0x00221820; wcount = 1.
- Back-to-back with im_ready = 1: sel=11, rs=29, rt=8, imm=4 then sel=20, imm=0x10 -> im_wdata = 0x8FA80004 then 0x08000010 in consecutive cycles at addresses 0x11, 0x12.
- sel=7, rs=7, rt=1, rd=2, shamt=4 -> rs forced to 0: im_wdata = 0x00011100.
- im_ready held 0, DEPTH=4, six beats offered -> in_ready low after 5 accepted; im_wdata held stable.
  - Release im_ready -> 5 writes in order, then in_ready returns high for the sixth beat.
- sel=25 -> err pulse, no im_we, wcount unchanged.
  - With ADDR_W=4, start_addr = 15, two legal beats -> addresses 15 then 0; wrap = 1.
- Reset asserted while WRITE is stalled with 3 words buffered -> im_we drops immediately; after release busy = 0 and wcount = 0.
  - With INSTR_ENCODER_CHKSUM_EN defined, chksum = 0x00221820 ^ 0x8FA80004 after the first two writes.
